// File: rtl/dmem_stage.sv
// Data-memory access stage: turns an EX/MEM load/store into a req/ack memory transaction and stalls until done.
// Optional build macro DMEM_TIMEOUT_EN adds a BUSY watchdog limited by TIMEOUT_CYCLES.
module dmem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [4:0]  rd_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_q;
  logic        access;
  logic        misaligned;
  logic        start;
  logic        finish;
  logic        timeout_hit;
  logic        timed_out;

  assign access     = MemRead_i | MemWrite_i;
  assign misaligned = addr_i[1:0] != 2'b00;
  assign start      = (state_q == IDLE) && access && !misaligned;
  assign finish     = (state_q == BUSY) && (mem_ack_i || timeout_hit);
  assign state_o    = state_q;

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        to_flag_q;

  assign timeout_hit = (state_q == BUSY) && !mem_ack_i &&
                       (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign timed_out   = to_flag_q;

  // to_flag_q is only ever high in the DONE cycle that follows an expired wait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q  <= 16'd0;
      to_flag_q <= 1'b0;
    end else begin
      to_flag_q <= timeout_hit;
      if (start) begin
        to_cnt_q <= 16'd0;
      end else if ((state_q == BUSY) && !mem_ack_i) begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    err_o   = 1'b0;
    WB_o    = WB_i;
    addr_o  = addr_i;
    rd_o    = rd_i;
    data_o  = 32'h0;
    case (state_q)
      IDLE: begin
        if (access && misaligned) begin
          err_o = 1'b1;
          WB_o  = 2'b00;
        end else if (access) begin
          stall_o = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (mem_ack_i || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (timed_out) begin
          err_o = 1'b1;
          WB_o  = 2'b00;
        end else if (!mem_we_o) begin
          data_o = load_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake: mem_req_o rises with the latched we/addr/wdata, which stay frozen
  // until the BUSY cycle in which mem_ack_i is sampled high; ack outside BUSY is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      load_q      <= 32'h0;
    end else if (start) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= MemWrite_i;
      mem_addr_o  <= addr_i;
      mem_wdata_o <= data_i;
    end else if (finish) begin
      mem_req_o <= 1'b0;
      if (mem_ack_i && !mem_we_o) begin
        load_q <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: scenario tasks plus a data_o scoreboard checked on each completion.
// Timeout scenarios build only when DMEM_TIMEOUT_EN is defined.
module tb_dmem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [1:0]  WB_i = 2'b00;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [4:0]  rd_i = 5'd0;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [4:0]  rd_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [1:0]  state_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        prev_stall = 1'b0;

  int          obs_stalls, obs_req, obs_unstable, obs_err;
  logic [1:0]  done_wb, done_state;
  logic [4:0]  done_rd;
  logic [31:0] done_addr;

  dmem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .WB_i(WB_i), .addr_i(addr_i), .data_i(data_i), .rd_i(rd_i),
    .stall_o(stall_o), .WB_o(WB_o), .addr_o(addr_o), .data_o(data_o), .rd_o(rd_o),
    .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: a stall falling edge marks the DONE cycle that MEM/WB captures
  always @(negedge clk or posedge rst_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !stall_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: completion seen with empty queue, data_o=%h", data_o);
        end else begin
          logic [31:0] exp;
          exp = exp_q.pop_front();
          if (data_o !== exp) begin
            failures++;
            $display("FAIL sb_data_o: got %h expected %h", data_o, exp);
          end
        end
      end
      prev_stall = stall_o;
    end
  end

  // driver tasks
  task automatic idle_inputs();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    WB_i       = 2'b00;
    addr_i     = 32'h0;
    data_i     = 32'h0;
    rd_i       = 5'd0;
    mem_ack_i  = 1'b0;
  endtask

  // Entered and left at posedge+1; ack is given in BUSY cycle n_busy (n_busy >= 1).
  task automatic drive_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int n_busy,
                              input logic [1:0] wb, input logic [4:0] rd);
    MemRead_i  = ~wr;
    MemWrite_i = wr;
    WB_i       = wb;
    addr_i     = addr;
    data_i     = wdata;
    rd_i       = rd;
    exp_q.push_back(wr ? 32'h0 : rdata);
    obs_stalls = 0; obs_req = 0; obs_unstable = 0; obs_err = 0;
    for (int c = 0; c <= n_busy + 1; c++) begin
      mem_ack_i   = (c == n_busy);
      mem_rdata_i = (c == n_busy) ? rdata : $urandom();
      @(negedge clk);
      if (stall_o) obs_stalls++;
      if (err_o) obs_err++;
      if (mem_req_o) begin
        obs_req++;
        if (mem_we_o !== wr || mem_addr_o !== addr || mem_wdata_o !== wdata) obs_unstable++;
      end
      if (c == n_busy + 1) begin
        done_wb    = WB_o;
        done_rd    = rd_o;
        done_addr  = addr_o;
        done_state = state_o;
      end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    WB_i   = 2'b11;
    addr_i = 32'hCAFE_0000;
    rd_i   = 5'd9;
    #2;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_maddr: got %h expected 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h expected 0", mem_wdata_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", err_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL rst_data: got %h expected 0", data_o); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", state_o); end
    checks++; if (WB_o !== 2'b11 || addr_o !== 32'hCAFE_0000 || rd_o !== 5'd9) begin
      failures++; $display("FAIL rst_passthru: got wb=%b addr=%h rd=%0d expected 11 cafe0000 9", WB_o, addr_o, rd_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    drive_access(1'b0, 32'h0000_0010, $urandom(), 32'hDEAD_BEEF, 1, 2'b11, 5'd7);
    idle_inputs();
    checks++; if (obs_stalls != 2) begin failures++; $display("FAIL load_stalls: got %0d expected 2", obs_stalls); end
    checks++; if (obs_req != 1) begin failures++; $display("FAIL load_req_cycles: got %0d expected 1", obs_req); end
    checks++; if (obs_unstable != 0) begin failures++; $display("FAIL load_req_fields: got %0d bad cycles expected 0", obs_unstable); end
    checks++; if (obs_err != 0) begin failures++; $display("FAIL load_err: got %0d err cycles expected 0", obs_err); end
    checks++; if (done_wb !== 2'b11 || done_rd !== 5'd7 || done_addr !== 32'h10) begin
      failures++; $display("FAIL load_done_ctrl: got wb=%b rd=%0d addr=%h expected 11 7 10", done_wb, done_rd, done_addr);
    end
    checks++; if (done_state !== 2'd2) begin failures++; $display("FAIL load_done_state: got %0d expected 2", done_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    drive_access(1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_0000, 4, 2'b01, 5'd3);
    idle_inputs();
    checks++; if (obs_stalls != 5) begin failures++; $display("FAIL store_stalls: got %0d expected 5", obs_stalls); end
    checks++; if (obs_req != 4) begin failures++; $display("FAIL store_req_cycles: got %0d expected 4", obs_req); end
    checks++; if (obs_unstable != 0) begin failures++; $display("FAIL store_req_fields: got %0d bad cycles expected 0", obs_unstable); end
    checks++; if (obs_err != 0) begin failures++; $display("FAIL store_err: got %0d err cycles expected 0", obs_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    MemRead_i = 1'b1;
    WB_i      = 2'b11;
    addr_i    = 32'h0000_0013;
    rd_i      = 5'd3;
    @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mis_stall: got %b expected 0", stall_o); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL mis_err: got %b expected 1", err_o); end
    checks++; if (WB_o !== 2'b00) begin failures++; $display("FAIL mis_wb: got %b expected 00", WB_o); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL mis_err_pulse: got %b expected 0", err_o); end
    checks++; if (mem_req_o !== 1'b0 || state_o !== 2'd0) begin
      failures++; $display("FAIL mis_no_req: got req=%b state=%0d expected 0 0", mem_req_o, state_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    WB_i      = 2'b10;
    addr_i    = 32'h0000_0055;
    rd_i      = 5'd4;
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL nm_stall: got %b expected 0", stall_o); end
    checks++; if (addr_o !== 32'h55 || WB_o !== 2'b10 || rd_o !== 5'd4) begin
      failures++; $display("FAIL nm_passthru: got addr=%h wb=%b rd=%0d expected 55 10 4", addr_o, WB_o, rd_o);
    end
    checks++; if (data_o !== 32'h0 || err_o !== 1'b0) begin
      failures++; $display("FAIL nm_data_err: got data=%h err=%b expected 0 0", data_o, err_o);
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 2'd0 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL nm_spurious_ack: got state=%0d req=%b expected 0 0", state_o, mem_req_o);
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    MemRead_i = 1'b1;
    WB_i      = 2'b11;
    addr_i    = 32'h0000_0040;
    rd_i      = 5'd5;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rmb_busy_req: got %b expected 1", mem_req_o); end
    #2;
    idle_inputs();
    rst_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b0 || state_o !== 2'd0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL rmb_async: got req=%b state=%0d stall=%b expected 0 0 0", mem_req_o, state_o, stall_o);
    end
    @(posedge clk); #1;
    rst_i     = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0 || state_o !== 2'd0 || stall_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL rmb_late_ack: got req=%b state=%0d stall=%b err=%b expected 0 0 0 0",
                           mem_req_o, state_o, stall_o, err_o);
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 2'd0 || err_o !== 1'b0 || data_o !== 32'h0) begin
      failures++; $display("FAIL rmb_no_done: got state=%0d err=%b data=%h expected 0 0 0", state_o, err_o, data_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      int          n;
      logic        wr;
      logic [1:0]  wb;
      logic [4:0]  rd;
      logic [31:0] a;
      n  = $urandom_range(1, 5);
      wr = 1'($urandom_range(0, 1));
      wb = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      a  = $urandom() & 32'hFFFF_FFFC;
      drive_access(wr, a, $urandom(), $urandom(), n, wb, rd);
      checks++; if (obs_stalls != n + 1) begin failures++; $display("FAIL b2b_stalls[%0d]: got %0d expected %0d", i, obs_stalls, n + 1); end
      checks++; if (obs_unstable != 0 || obs_req != n) begin
        failures++; $display("FAIL b2b_req[%0d]: got unstable=%0d req=%0d expected 0 %0d", i, obs_unstable, obs_req, n);
      end
      checks++; if (done_wb !== wb || done_rd !== rd || done_addr !== a) begin
        failures++; $display("FAIL b2b_ctrl[%0d]: got wb=%b rd=%0d addr=%h expected %b %0d %h", i, done_wb, done_rd, done_addr, wb, rd, a);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int stalls;
    int reqs;
    stalls = 0;
    reqs   = 0;
    MemRead_i = 1'b1;
    WB_i      = 2'b11;
    addr_i    = 32'h0000_0080;
    rd_i      = 5'd6;
    exp_q.push_back(32'h0);
    for (int c = 0; c <= TO + 1; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (mem_req_o) reqs++;
      if (c == TO + 1) begin
        checks++; if (err_o !== 1'b1 || WB_o !== 2'b00 || data_o !== 32'h0) begin
          failures++; $display("FAIL to_done: got err=%b wb=%b data=%h expected 1 00 0", err_o, WB_o, data_o);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if (stalls != TO + 1 || reqs != TO) begin
      failures++; $display("FAIL to_cycles: got stalls=%0d req=%0d expected %0d %0d", stalls, reqs, TO + 1, TO);
    end
    @(posedge clk); #1;
    drive_access(1'b0, 32'h0000_0084, 32'h0, 32'h0BAD_F00D, TO, 2'b11, 5'd6);
    idle_inputs();
    checks++; if (obs_stalls != TO + 1 || obs_err != 0) begin
      failures++; $display("FAIL to_ack_wins: got stalls=%0d err=%0d expected %0d 0", obs_stalls, obs_err, TO + 1);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_long_wait();
    drive_access(1'b0, 32'h0000_0100, 32'h0, 32'h5A5A_A5A5, 20, 2'b11, 5'd8);
    idle_inputs();
    checks++; if (obs_stalls != 21 || obs_err != 0) begin
      failures++; $display("FAIL long_wait: got stalls=%0d err=%0d expected 21 0", obs_stalls, obs_err);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misalign();
    test_nonmem();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
